// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32 multiply-unit types, encodings and helpers
package rv32i_types;

  localparam int RV_XLEN = 32;

  typedef enum logic [1:0] {
    MUL_FU_IDLE  = 2'd0,
    MUL_FU_BUSY  = 2'd1,
    MUL_FU_RESP  = 2'd2,
    MUL_FU_ABORT = 2'd3
  } mul_fu_state_t;

  localparam logic [1:0] MUL_TYPE_UU = 2'b00;
  localparam logic [1:0] MUL_TYPE_SS = 2'b01;
  localparam logic [1:0] MUL_TYPE_SU = 2'b10;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  function automatic logic [1:0] mul_funct3_to_type(input logic [2:0] funct3);
    logic [1:0] t;
    case (funct3)
      F3_MULH:   t = MUL_TYPE_SS;
      F3_MULHSU: t = MUL_TYPE_SU;
      F3_MULHU:  t = MUL_TYPE_UU;
      default:   t = MUL_TYPE_UU;
    endcase
    return t;
  endfunction

  // Only MUL wants the low half; every high-half variant shares the upper word.
  function automatic logic [RV_XLEN-1:0] mul_result_sel(input logic [2:0] funct3,
                                                        input logic [2*RV_XLEN-1:0] p);
    return (funct3 == F3_MUL) ? p[RV_XLEN-1:0] : p[2*RV_XLEN-1:RV_XLEN];
  endfunction

endpackage

// File: rtl/mul_fu_ctrl_if.sv
// rtl/mul_fu_ctrl_if.sv - issue, multiplier and CDB signals of the multiply FU controller
interface mul_fu_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PHYS_W    = 6
);
  logic                 flush;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [2:0]           iss_funct3;
  logic [XLEN-1:0]      iss_rs1_v;
  logic [XLEN-1:0]      iss_rs2_v;
  logic [ROB_IDX_W-1:0] iss_rob_idx;
  logic [PHYS_W-1:0]    iss_rd_phys;
  logic                 mul_start;
  logic [1:0]           mul_type;
  logic [XLEN-1:0]      mul_a;
  logic [XLEN-1:0]      mul_b;
  logic [2*XLEN-1:0]    mul_p;
  logic                 mul_done;
  logic                 cdb_valid;
  logic                 cdb_ready;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [PHYS_W-1:0]    cdb_rd_phys;
  logic [XLEN-1:0]      cdb_data;

  modport master (
    input  flush, iss_valid, iss_funct3, iss_rs1_v, iss_rs2_v, iss_rob_idx, iss_rd_phys,
           mul_p, mul_done, cdb_ready,
    output iss_ready, mul_start, mul_type, mul_a, mul_b,
           cdb_valid, cdb_rob_idx, cdb_rd_phys, cdb_data
  );

  modport slave (
    output flush, iss_valid, iss_funct3, iss_rs1_v, iss_rs2_v, iss_rob_idx, iss_rd_phys,
           mul_p, mul_done, cdb_ready,
    input  iss_ready, mul_start, mul_type, mul_a, mul_b,
           cdb_valid, cdb_rob_idx, cdb_rd_phys, cdb_data
  );
endinterface

// File: rtl/mul_fu_ctrl.sv
// rtl/mul_fu_ctrl.sv - multiply functional-unit controller: issue accept, multiplier start/done, CDB result
module mul_fu_ctrl
  import rv32i_types::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PHYS_W    = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_fu_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE  = MUL_FU_IDLE;
  localparam logic [1:0] S_BUSY  = MUL_FU_BUSY;
  localparam logic [1:0] S_RESP  = MUL_FU_RESP;
  localparam logic [1:0] S_ABORT = MUL_FU_ABORT;

  logic [1:0]           state;
  logic [1:0]           op_q;
  logic [1:0]           type_q;
  logic [XLEN-1:0]      a_q;
  logic [XLEN-1:0]      b_q;
  logic [ROB_IDX_W-1:0] rob_q;
  logic [PHYS_W-1:0]    rd_q;
  logic [XLEN-1:0]      data_q;

  logic       accept;
  logic [2:0] f3_eff;

  assign bus.iss_ready   = (state == S_IDLE) && !bus.flush;
  assign accept          = bus.iss_valid && bus.iss_ready;
  // Illegal funct3[2]=1 encodings collapse to plain MUL.
  assign f3_eff          = bus.iss_funct3[2] ? F3_MUL : bus.iss_funct3;

  // Multiplier inputs come straight from flops so the live product stays stable.
  assign bus.mul_start   = (state == S_BUSY);
  assign bus.mul_type    = type_q;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;

  assign bus.cdb_valid   = (state == S_RESP);
  assign bus.cdb_rob_idx = rob_q;
  assign bus.cdb_rd_phys = rd_q;
  assign bus.cdb_data    = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      type_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rob_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= f3_eff[1:0];
            type_q <= mul_funct3_to_type(f3_eff);
            a_q    <= bus.iss_rs1_v;
            b_q    <= bus.iss_rs2_v;
            rob_q  <= bus.iss_rob_idx;
            rd_q   <= bus.iss_rd_phys;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.flush) begin
            // A running multiply cannot be cancelled; drain it in ABORT.
            state <= bus.mul_done ? S_IDLE : S_ABORT;
          end else if (bus.mul_done) begin
            data_q <= mul_result_sel({1'b0, op_q}, bus.mul_p);
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.flush || bus.cdb_ready) begin
            state <= S_IDLE;
          end
        end
        S_ABORT: begin
          if (bus.mul_done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      assert (!bus.iss_funct3[2])
        else $error("mul_fu_ctrl: illegal funct3 %b at multiply issue", bus.iss_funct3);
    end
  end
`endif

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// tb/tb_mul_fu_ctrl.sv - self-checking bench for mul_fu_ctrl with a 4-cycle multiplier model
module tb_mul_fu_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_fu_ctrl_if #(.XLEN(32), .ROB_IDX_W(5), .PHYS_W(6)) bus ();

  mul_fu_ctrl #(.XLEN(32), .ROB_IDX_W(5), .PHYS_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Multiplier model: once started it runs to done regardless of start, done on its 4th cycle.
  int mcnt;
  always @(posedge clk) begin
    if (rst)                         mcnt <= 0;
    else if (mcnt == 0 && bus.mul_start) mcnt <= 1;
    else if (mcnt == 3)              mcnt <= 0;
    else if (mcnt != 0)              mcnt <= mcnt + 1;
  end

  logic [63:0] prod;
  always_comb begin
    case (bus.mul_type)
      2'b01:   prod = {{32{bus.mul_a[31]}}, bus.mul_a} * {{32{bus.mul_b[31]}}, bus.mul_b};
      2'b10:   prod = {{32{bus.mul_a[31]}}, bus.mul_a} * {32'h0, bus.mul_b};
      default: prod = {32'h0, bus.mul_a} * {32'h0, bus.mul_b};
    endcase
  end
  assign bus.mul_done = (mcnt == 3);
  assign bus.mul_p    = bus.mul_done ? prod : 64'hDEAD_BEEF_0BAD_F00D;

  function automatic logic [1:0] ref_type(input logic [2:0] f3);
    case (f3)
      3'b001:  return 2'b01;
      3'b010:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'b000:  p = 64'(ua * ub);
      3'b001:  p = 64'(sa * sb);
      3'b010:  p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rob, input logic [5:0] rd);
    bus.iss_funct3  = f3;
    bus.iss_rs1_v   = a;
    bus.iss_rs2_v   = b;
    bus.iss_rob_idx = rob;
    bus.iss_rd_phys = rd;
    bus.iss_valid   = 1'b1;
    #1;
    chk("accept_ready", bus.iss_ready, 1);
    tick();
    bus.iss_valid   = 1'b0;
    bus.iss_rs1_v   = $urandom;
    bus.iss_rs2_v   = $urandom;
    bus.iss_rob_idx = 5'($urandom);
    bus.iss_rd_phys = 6'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rob, input logic [5:0] rd,
                        input logic [1:0] et, input logic [31:0] ed, input int hold);
    int lat;
    issue(f3, a, b, rob, rd);
    lat = 1;
    while (bus.cdb_valid !== 1'b1 && lat < 20) begin
      chk("busy_start", bus.mul_start, 1);
      chk("busy_type", bus.mul_type, et);
      chk("busy_a", bus.mul_a, a);
      chk("busy_b", bus.mul_b, b);
      chk("busy_ready", bus.iss_ready, 0);
      tick();
      lat++;
    end
    chk("latency", lat, 5);
    bus.cdb_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("hold_valid", bus.cdb_valid, 1);
      chk("hold_data", bus.cdb_data, ed);
      chk("hold_ready", bus.iss_ready, 0);
      chk("hold_start", bus.mul_start, 0);
      tick();
    end
    bus.cdb_ready = 1'b1;
    #1;
    chk("cdb_valid", bus.cdb_valid, 1);
    chk("cdb_data", bus.cdb_data, ed);
    chk("cdb_rob", bus.cdb_rob_idx, rob);
    chk("cdb_rd", bus.cdb_rd_phys, rd);
    chk("resp_start", bus.mul_start, 0);
    tick();
    chk("post_valid", bus.cdb_valid, 0);
    chk("post_ready", bus.iss_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iss_ready"}, bus.iss_ready, 1);
    chk({tag, "_start"}, bus.mul_start, 0);
    chk({tag, "_valid"}, bus.cdb_valid, 0);
    chk({tag, "_type"}, bus.mul_type, 0);
    chk({tag, "_a"}, bus.mul_a, 0);
    chk({tag, "_b"}, bus.mul_b, 0);
    chk({tag, "_data"}, bus.cdb_data, 0);
    chk({tag, "_rob"}, bus.cdb_rob_idx, 0);
    chk({tag, "_rd"}, bus.cdb_rd_phys, 0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rob;
    logic [5:0]  rd;
    logic [1:0]  typ;
    logic [31:0] data;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, 6'd9,  2'b00, 32'hFFFF_FFEB, 0};
    vecs[1] = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd4, 6'd10, 2'b01, 32'hFFFF_FFFF, 0};
    vecs[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 6'd11, 2'b00, 32'hFFFF_FFFE, 0};
    vecs[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 6'd12, 2'b10, 32'hFFFF_FFFF, 3};
    vecs[4] = '{3'b000, 32'h0000_0005, 32'h0000_0006, 5'd1, 6'd2,  2'b00, 32'h0000_001E, 0};
    vecs[5] = '{3'b011, 32'h8000_0000, 32'h0000_0004, 5'd31, 6'd63, 2'b00, 32'h0000_0002, 1};

    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.iss_valid   = 1'b0;
    bus.iss_funct3  = 3'b000;
    bus.iss_rs1_v   = '0;
    bus.iss_rs2_v   = '0;
    bus.iss_rob_idx = '0;
    bus.iss_rd_phys = '0;
    bus.cdb_ready   = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rob, vecs[i].rd,
             vecs[i].typ, vecs[i].data, vecs[i].hold);

    // Flush in cycle 2: drain in ABORT until done, then a fresh MUL 5x6.
    issue(3'b000, 32'h0000_1234, 32'h0000_0010, 5'd7, 6'd20);
    tick();
    bus.flush = 1'b1;
    #1;
    chk("flush_busy_ready", bus.iss_ready, 0);
    chk("flush_busy_valid", bus.cdb_valid, 0);
    tick();
    bus.flush = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      #1;
      chk("abort_start", bus.mul_start, 0);
      chk("abort_ready", bus.iss_ready, 0);
      chk("abort_valid", bus.cdb_valid, 0);
      tick();
    end
    #1;
    chk("abort_exit_ready", bus.iss_ready, 1);
    chk("abort_exit_valid", bus.cdb_valid, 0);
    run_op(3'b000, 32'd5, 32'd6, 5'd8, 6'd21, 2'b00, 32'd30, 0);

    // Flush coincident with mul_done: result dropped, IDLE next.
    issue(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd9, 6'd22);
    repeat (3) tick();
    bus.flush = 1'b1;
    #1;
    chk("flushdone_valid", bus.cdb_valid, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flushdone_next_valid", bus.cdb_valid, 0);
    chk("flushdone_next_ready", bus.iss_ready, 1);
    chk("flushdone_next_start", bus.mul_start, 0);
    tick();
    chk("flushdone_late_valid", bus.cdb_valid, 0);

    // Flush while the result waits in RESP.
    bus.cdb_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd4, 5'd10, 6'd23);
    repeat (4) tick();
    chk("resp_wait_valid", bus.cdb_valid, 1);
    chk("resp_wait_data", bus.cdb_data, 32'd12);
    bus.flush = 1'b1;
    #1;
    chk("resp_flush_ready", bus.iss_ready, 0);
    tick();
    bus.flush     = 1'b0;
    bus.cdb_ready = 1'b1;
    #1;
    chk("resp_flush_valid", bus.cdb_valid, 0);
    chk("resp_flush_idle", bus.iss_ready, 1);

    // Flush in IDLE blocks acceptance.
    bus.flush       = 1'b1;
    bus.iss_valid   = 1'b1;
    bus.iss_funct3  = 3'b000;
    #1;
    chk("idle_flush_ready", bus.iss_ready, 0);
    tick();
    bus.flush     = 1'b0;
    bus.iss_valid = 1'b0;
    #1;
    chk("idle_flush_noaccept", bus.mul_start, 0);
    chk("idle_flush_ready_after", bus.iss_ready, 1);

    // Reset in cycle 3 of an op, then MULHU 2x3.
    issue(3'b001, 32'hABCD_0123, 32'h0000_7777, 5'd11, 6'd24);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    run_op(3'b011, 32'd2, 32'd3, 5'd12, 6'd25, 2'b00, 32'd0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 3));
      a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      run_op(f3, a, b, 5'($urandom), 6'($urandom), ref_type(f3), ref_result(f3, a, b),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
